sub_bytes_iter: RTL and testbench

//   Iterative AES SubBytes stage; sits directly upstream of shift_rows and feeds its input_state.

---
 rtl/sub_bytes_iter.sv | 135 +++++++++++++
 tb/tb_sub_bytes_iter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_iter.sv
// ---------------------------------------------------------------------------
// sub_bytes_iter
//   Iterative AES SubBytes stage. Accepts a 128-bit state over a valid/ready
//   handshake, applies the forward AES S-box to all 16 bytes using NUM_SBOX
//   table instances over 16/NUM_SBOX cycles, then presents the result until
//   the downstream (shift_rows) side accepts it.
//   Byte i = state[8*i +: 8], column-major, i = 4*col + row.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous reset, active-high
//   in_valid   in   1    in_state valid
//   in_ready   out  1    block can accept a state (IDLE and not in reset)
//   in_state   in   128  state to substitute
//   out_valid  out  1    out_state holds a finished result
//   out_ready  in   1    consumer accepts result
//   out_state  out  128  substituted state (the working register)
//   busy       out  1    high while substituting or holding a result
// ---------------------------------------------------------------------------
module sub_bytes_iter #(
    parameter int unsigned NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned N  = 16 / NUM_SBOX;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SH = $clog2(8 * NUM_SBOX);
    localparam int unsigned CHUNK_W = 8 * NUM_SBOX;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
        NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
        $error("sub_bytes_iter: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic [127:0]  r_work;

    logic               w_accept;
    logic [CW+SH-1:0]   w_lsb_full;
    logic [6:0]         w_chunk_lsb;
    logic [CHUNK_W-1:0] w_chunk_in;
    logic [CHUNK_W-1:0] w_sub_chunk;

    // Chunk bit offset = cnt * 8 * NUM_SBOX; both factors are powers of two,
    // so it is just the counter shifted into the upper bits of a 7-bit index.
    // With NUM_SBOX=16 the counter is always 0 and the extra top bit drops out.
    assign w_lsb_full  = {r_cnt, {SH{1'b0}}};
    assign w_chunk_lsb = w_lsb_full[6:0];
    assign w_chunk_in  = r_work[w_chunk_lsb +: CHUNK_W];

    for (genvar gi = 0; gi < NUM_SBOX; gi++) begin : g_sbox
        assign w_sub_chunk[8*gi +: 8] = sbox(w_chunk_in[8*gi +: 8]);
    end

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_state = r_work;
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = S_SUB;
            S_SUB:  if (r_cnt == CNT_LAST) w_next_state = S_DONE;
            S_DONE: if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_work <= in_state;
                        r_cnt  <= '0;
                    end
                end
                S_SUB: begin
                    r_work[w_chunk_lsb +: CHUNK_W] <= w_sub_chunk;
                    r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
module tb_sub_bytes_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index k hosts an instance with NUM_SBOX = 1 << k; index 2 is the default (4).
    logic         in_valid_a  [5];
    logic         in_ready_a  [5];
    logic [127:0] in_state_a  [5];
    logic         out_valid_a [5];
    logic         out_ready_a [5];
    logic [127:0] out_state_a [5];
    logic         busy_a      [5];

    for (genvar g = 0; g < 5; g++) begin : g_dut
        sub_bytes_iter #(.NUM_SBOX(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_state  (in_state_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_state (out_state_a[g]),
            .busy      (busy_a[g])
        );
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] ref_sbox [256];

    // Reference S-box from its mathematical definition: GF(2^8) inverse
    // followed by the affine transform.
    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic void build_ref();
        logic [7:0] x, y, inv, r, s;
        for (int xi = 0; xi < 256; xi++) begin
            x = 8'(xi);
            inv = 8'h00;
            for (int yi = 1; yi < 256; yi++) begin
                y = 8'(yi);
                if (x != 8'h00 && gf_mul(x, y) == 8'h01) inv = y;
            end
            s = inv; r = inv;
            for (int j = 0; j < 4; j++) begin
                r = rotl1(r);
                s = s ^ r;
            end
            ref_sbox[x] = s ^ 8'h63;
        end
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] st_in);
        logic [127:0] st, res;
        st = st_in; res = '0;
        for (int i = 0; i < 16; i++) begin
            res = {ref_sbox[st[7:0]], res[127:8]};
            st  = st >> 8;
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on instance k: accept, wait for out_valid with a
    // cycle budget, check latency/result, then complete the output handshake.
    task automatic run_one(input int k, input logic [127:0] st, input int exp_lat,
                           input string tag, output logic [127:0] got);
        logic [127:0] exp;
        int lat;
        exp = ref_sub(st);
        chk({tag, "_rdy"}, 128'(in_ready_a[k]), 128'(1));
        in_valid_a[k] = 1'b1;
        in_state_a[k] = st;
        tick();
        in_valid_a[k] = 1'b0;
        in_state_a[k] = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!out_valid_a[k] && lat < 64) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_out"}, out_state_a[k], exp);
        chk({tag, "_busy"}, 128'(busy_a[k]), 128'(1));
        got = out_state_a[k];
        out_ready_a[k] = 1'b1;
        tick();
        out_ready_a[k] = 1'b0;
        chk({tag, "_ovld_clr"}, 128'(out_valid_a[k]), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] got, st, held;
        logic [127:0] bb_st [3];
        logic [127:0] bb_exp [3];
        logic [7:0]   pat [4];
        int sent, rcvd, last_hs;

        build_ref();
        for (int k = 0; k < 5; k++) begin
            in_valid_a[k] = 1'b0;
            in_state_a[k] = '0;
            out_ready_a[k] = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        in_valid_a[2] = 1'b1;
        tick();
        tick();
        chk("rst_in_ready_low", 128'(in_ready_a[2]), 128'(0));
        in_valid_a[2] = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid_a[2]), 128'(0));
        chk("rst_busy", 128'(busy_a[2]), 128'(0));
        chk("rst_in_ready", 128'(in_ready_a[2]), 128'(1));
        chk("rst_work_zero", out_state_a[2], 128'(0));

        // S-box spot values on uniform states
        pat[0] = 8'h00; pat[1] = 8'h53; pat[2] = 8'hff; pat[3] = 8'h01;
        for (int p = 0; p < 4; p++) begin
            run_one(2, {16{pat[p]}}, 4, "spot", got);
        end
        chk("spot_ff_const", ref_sub({16{8'hff}}), {16{8'h16}});

        // FIPS-197 round-1 SubBytes vector
        run_one(2, 128'h0848f8e92a8dc69a2be2f4a0bee33d19, 4, "fips", got);
        chk("fips_const", got, 128'h3052411ee55db4b8f198bfe0ae1127d4);

        // Randomized states
        for (int r = 0; r < 6; r++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            run_one(2, st, 4, "rand", got);
        end

        // Backpressure: hold out_ready low for 10 cycles with a competing input
        st = {$urandom, $urandom, $urandom, $urandom};
        in_valid_a[2] = 1'b1;
        in_state_a[2] = st;
        tick();
        in_valid_a[2] = 1'b0;
        repeat (4) tick();
        chk("bp_valid_up", 128'(out_valid_a[2]), 128'(1));
        held = ref_sub(st);
        in_valid_a[2] = 1'b1;
        in_state_a[2] = ~st;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_valid_hold", 128'(out_valid_a[2]), 128'(1));
            chk("bp_state_hold", out_state_a[2], held);
            chk("bp_in_ready", 128'(in_ready_a[2]), 128'(0));
        end
        in_valid_a[2] = 1'b0;
        out_ready_a[2] = 1'b1;
        tick();
        out_ready_a[2] = 1'b0;
        chk("bp_drained", 128'(out_valid_a[2]), 128'(0));
        chk("bp_no_accept", 128'(busy_a[2]), 128'(0));

        // Back-to-back with in_valid held and out_ready high
        for (int i = 0; i < 3; i++) begin
            bb_st[i]  = {$urandom, $urandom, $urandom, $urandom};
            bb_exp[i] = ref_sub(bb_st[i]);
        end
        out_ready_a[2] = 1'b1;
        sent = 0; rcvd = 0; last_hs = -1;
        for (int c = 0; c < 100 && rcvd < 3; c++) begin
            logic acc;
            in_valid_a[2] = (sent < 3);
            if (sent < 3) in_state_a[2] = bb_st[sent];
            #0;
            acc = in_valid_a[2] && in_ready_a[2];
            if (out_valid_a[2]) begin
                chk("b2b_out", out_state_a[2], bb_exp[rcvd]);
                if (rcvd > 0) chk("b2b_spacing", 128'(c - last_hs), 128'(6));
                last_hs = c;
                rcvd++;
            end
            tick();
            if (acc) sent++;
        end
        chk("b2b_count", 128'(rcvd), 128'(3));
        in_valid_a[2] = 1'b0;
        out_ready_a[2] = 1'b0;
        tick();

        // Reset two edges after accept
        in_valid_a[2] = 1'b1;
        in_state_a[2] = {$urandom, $urandom, $urandom, $urandom};
        tick();
        in_valid_a[2] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 128'(in_ready_a[2]), 128'(0));
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid_a[2]), 128'(0));
        chk("midrst_busy", 128'(busy_a[2]), 128'(0));
        st = {$urandom, $urandom, $urandom, $urandom};
        run_one(2, st, 4, "post_rst", got);

        // NUM_SBOX sweep on the FIPS vector
        for (int k = 0; k < 5; k++) begin
            run_one(k, 128'h0848f8e92a8dc69a2be2f4a0bee33d19, 16 >> k, "sweep", got);
            chk("sweep_const", got, 128'h3052411ee55db4b8f198bfe0ae1127d4);
        end

        // Exhaustive S-box: 256 byte values, 16 per state
        for (int j = 0; j < 16; j++) begin
            st = '0;
            for (int i = 15; i >= 0; i--) st = {st[119:0], 8'(16 * j + i)};
            run_one(2, st, 4, "exh", got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
